// File: rtl/serdes_check_pkg.sv
// Shared types and defaults for the SN65LV1224 word checker.
package serdes_check_pkg;
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_ACQUIRE   = 2'd1,
    ST_CHECK     = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_LOCK_COUNT = 16;
  localparam int DEF_LOSS_COUNT = 4;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int LOSS_CNT_W     = 16;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic fast_clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_sync;

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/deserializer_word_checker.sv
// Incrementing-pattern checker for a deserializer word stream with lock tracking.
// Optional first-error capture ports when CHECKER_CAPTURE_EN is defined.
module deserializer_word_checker
  import serdes_check_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT = DEF_LOSS_COUNT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  fast_clock,
  input  logic                  reset,
  input  logic                  lock_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  clear_counts,
  output logic                  aligned,
  output logic                  error_pulse,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [LOSS_CNT_W-1:0] loss_count
`ifdef CHECKER_CAPTURE_EN
  ,
  output logic                  first_err_valid,
  output logic [WIDTH-1:0]      first_err_expected,
  output logic [WIDTH-1:0]      first_err_received,
  output logic [CNT_WIDTH-1:0]  first_err_index
`endif
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  logic                  w_lock_sync, w_lock_ok, w_match, w_mis, w_loss;
  logic [WIDTH-1:0]      r_d_q, r_exp;
  state_t                r_state, w_state_nxt;
  logic [GW-1:0]         r_good_run, w_good_nxt;
  logic [BW-1:0]         r_bad_run, w_bad_nxt;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_word_count, r_error_count;
  logic [LOSS_CNT_W-1:0] r_loss_count;

  // Synchronizer resets to the deasserted (high) lock_n level.
  sync_2ff #(.RST_VAL(1'b1)) u_lock_sync (
    .fast_clock (fast_clock),
    .reset      (reset),
    .i_d        (lock_n),
    .o_q        (w_lock_sync)
  );
  assign w_lock_ok = ~w_lock_sync;

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      r_d_q <= '0;
      r_exp <= WIDTH'(1);
    end else begin
      r_d_q <= data_in;
      r_exp <= r_d_q + WIDTH'(1);
    end
  end

  assign w_match = (r_d_q == r_exp);
  assign w_mis   = (r_state == ST_CHECK) && !w_match;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_run;
    w_bad_nxt   = r_bad_run;
    w_loss      = 1'b0;
    unique case (r_state)
      ST_WAIT_LOCK: begin
        w_good_nxt = '0;
        w_bad_nxt  = '0;
        if (w_lock_ok) w_state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (!w_lock_ok) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_good_nxt  = '0;
        end else if (w_match) begin
          if (r_good_run == GW'(LOCK_COUNT - 1)) begin
            w_state_nxt = ST_CHECK;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_good_nxt = r_good_run + GW'(1);
          end
        end else begin
          w_good_nxt = '0;
        end
      end
      ST_CHECK: begin
        w_bad_nxt = w_match ? '0 : r_bad_run + BW'(1);
        // Lock loss wins over the bad-run exit so a loss is counted once.
        if (!w_lock_ok) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_loss      = 1'b1;
          w_bad_nxt   = '0;
        end else if (!w_match && r_bad_run == BW'(LOSS_COUNT - 1)) begin
          w_state_nxt = ST_ACQUIRE;
          w_loss      = 1'b1;
          w_bad_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      r_state       <= ST_WAIT_LOCK;
      r_good_run    <= '0;
      r_bad_run     <= '0;
      r_err         <= 1'b0;
      r_word_count  <= '0;
      r_error_count <= '0;
      r_loss_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_run <= w_good_nxt;
      r_bad_run  <= w_bad_nxt;
      r_err      <= w_mis;
      if (clear_counts) begin
        r_word_count  <= '0;
        r_error_count <= '0;
        r_loss_count  <= '0;
      end else begin
        if (r_state == ST_CHECK && r_word_count != '1) r_word_count <= r_word_count + CNT_WIDTH'(1);
        if (w_mis && r_error_count != '1) r_error_count <= r_error_count + CNT_WIDTH'(1);
        if (w_loss && r_loss_count != '1) r_loss_count <= r_loss_count + LOSS_CNT_W'(1);
      end
    end
  end

  assign aligned     = (r_state == ST_CHECK);
  assign error_pulse = r_err;
  assign word_count  = r_word_count;
  assign error_count = r_error_count;
  assign loss_count  = r_loss_count;

`ifdef CHECKER_CAPTURE_EN
  logic                 r_fe_valid;
  logic [WIDTH-1:0]     r_fe_exp, r_fe_rcv;
  logic [CNT_WIDTH-1:0] r_fe_idx;

  always_ff @(posedge fast_clock) begin
    if (reset || clear_counts) begin
      r_fe_valid <= 1'b0;
      r_fe_exp   <= '0;
      r_fe_rcv   <= '0;
      r_fe_idx   <= '0;
    end else if (w_mis && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_exp   <= r_exp;
      r_fe_rcv   <= r_d_q;
      r_fe_idx   <= r_word_count;
    end
  end

  assign first_err_valid    = r_fe_valid;
  assign first_err_expected = r_fe_exp;
  assign first_err_received = r_fe_rcv;
  assign first_err_index    = r_fe_idx;
`endif
endmodule

// File: doc/deserializer_word_checker.md
DESERIALIZER_WORD_CHECKER -- requirements
Module: deserializer_word_checker

Interface
REQ-001 Parameter WIDTH, default 10, parallel word width from the SN65LV1224 deserializer.
REQ-002 Parameter LOCK_COUNT, default 16, consecutive good words needed to declare alignment.
REQ-003 Parameter LOSS_COUNT, default 4, consecutive bad words in CHECK needed to declare loss.
REQ-004 Parameter CNT_WIDTH, default 32, width of word_count and error_count.
REQ-005 fast_clock  input  1  recovered clock (deserializer RCLK); all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 lock_n  input  1  deserializer LOCK, active-low, asynchronous to fast_clock.
REQ-008 data_in  input  WIDTH  deserializer ROUT word, valid every fast_clock cycle.
REQ-009 clear_counts  input  1  one-cycle pulse; zeroes word_count, error_count and loss_count.
REQ-010 aligned  output  1  high only in state CHECK.
REQ-011 error_pulse  output  1  one-cycle pulse per mismatched word in CHECK.
REQ-012 word_count  output  CNT_WIDTH  words compared in CHECK.
REQ-013 error_count  output  CNT_WIDTH  mismatches in CHECK.
REQ-014 loss_count  output  16  CHECK-to-WAIT_LOCK or CHECK-to-ACQUIRE exits.

Function
REQ-015 The checked pattern SHALL be an incrementing word sequence: the word after w is (w+1) mod 2^WIDTH, so 1023 wraps to 0.
REQ-016 lock_n SHALL pass through a two-flop synchronizer; lock_ok is the inverted synchronizer output.
REQ-017 data_in SHALL be registered into d_q; expected SHALL be (previous d_q)+1, truncated to WIDTH.
REQ-018 Comparison SHALL use d_q against expected; error_pulse and all counters update 2 edges after data_in is sampled.
REQ-019 States: WAIT_LOCK, ACQUIRE, CHECK.
REQ-020 WAIT_LOCK: go to ACQUIRE when lock_ok=1; good_run cleared.
REQ-021 ACQUIRE: good_run increments on match, clears on mismatch; go to CHECK when good_run reaches LOCK_COUNT-1 and the current word matches.
REQ-022 CHECK: word_count +1 every cycle; on mismatch error_count +1, error_pulse=1, bad_run +1; on match bad_run cleared.
REQ-023 CHECK: when bad_run reaches LOSS_COUNT, go to ACQUIRE and increment loss_count.
REQ-024 Any state: lock_ok=0 forces WAIT_LOCK next edge; from CHECK this also increments loss_count; lock loss takes priority over the bad_run exit (single increment).
REQ-025 Mismatches in WAIT_LOCK or ACQUIRE SHALL NOT touch error_count or error_pulse.
REQ-026 All counters SHALL saturate at all-ones, never wrap.
REQ-027 clear_counts coinciding with an increment: clear wins, the counter reads 0 next cycle.

Reset
REQ-028 Reset SHALL give state=WAIT_LOCK, aligned=0, error_pulse=0, all counters 0, d_q=0, synchronizer flops = lock_n deasserted.
REQ-029 Reset mid-CHECK SHALL NOT increment loss_count.

Configuration
REQ-030 Macro CHECKER_CAPTURE_EN: defined adds outputs first_err_valid (1), first_err_expected (WIDTH), first_err_received (WIDTH), first_err_index (CNT_WIDTH = word_count at mismatch); latched on first CHECK mismatch, held until reset or clear_counts.
REQ-031 Macro undefined: these ports and registers SHALL not exist; all other behaviour is identical.

Structure
REQ-032 Shared package serdes_check_pkg SHALL hold the state encoding, default WIDTH/LOCK_COUNT/LOSS_COUNT/CNT_WIDTH and the 16-bit loss-counter width.
REQ-033 The lock_n synchronizer SHALL be sub-module sync_2ff; everything else is inline.

Verification
REQ-034 lock_n=0 with words 0,1,2,... -> aligned=1 after exactly LOCK_COUNT matching words plus pipeline (2 edges); error_count=0.
REQ-035 In CHECK, inject one word 0x155 in place of 0x100 -> one error_pulse, error_count=1; the next word 0x101 is compared against 0x156 -> second mismatch, then resync on 0x102 vs 0x102 only if bad_run stays below 4.
REQ-036 In CHECK, stream 1022,1023,0,1 -> no errors (wrap-around).
REQ-037 In CHECK, 4 consecutive random words -> aligned=0, loss_count=1; re-acquire after 16 good words.
REQ-038 lock_n=1 during CHECK -> WAIT_LOCK within 3 edges, loss_count=1; with error pending in same cycle loss_count still 1.
REQ-039 clear_counts on the cycle of a mismatch -> error_count=0 next cycle; with CHECKER_CAPTURE_EN, first_err_valid=0.
